// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg: pipelined WIDTH-bit carry-propagate adder.
// The add is cut into SEG-bit ripple segments, one segment per stage, with
// the inter-segment carry registered. Operand segments not yet consumed ride
// along in skew registers; finished result segments ride along in deskew
// registers so the full sum lines up at the last stage. A single global
// advance enable (adv) moves the whole pipe at once.

// Single-bit full adder cell.
module adder_full (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// SEG-bit ripple chain built from adder_full cells.
module adder_seg_ripple #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_s,
    output logic           o_cout
);

    logic [SEG:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar j = 0; j < SEG; j++) begin : g_bit
        adder_full u_fa (
            .i_a    (i_a[j]),
            .i_b    (i_b[j]),
            .i_cin  (w_c[j]),
            .o_s    (o_s[j]),
            .o_cout (w_c[j+1])
        );
    end

    assign o_cout = w_c[SEG];

endmodule

// Top: segmented pipelined adder with valid/ready streaming.
module adder_pipe_seg #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STAGES = (SEG >= 1) ? (WIDTH / SEG) : 1;

    if (SEG < 1) begin : g_bad_seg
        $error("adder_pipe_seg: SEG must be at least 1");
    end else if ((WIDTH % SEG) != 0) begin : g_bad_width
        $error("adder_pipe_seg: WIDTH must be an integer multiple of SEG");
    end

    logic w_adv;

    // The pipe only moves as a whole: when the output slot is empty or being
    // drained. Accepting a beat never depends on in_valid.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operand bits still waiting to be added when the beat reaches stage k.
        localparam int REM = WIDTH - k * SEG;

        logic [REM-1:0]       w_a_rem;
        logic [REM-1:0]       w_b_rem;
        logic                 w_cin;
        logic                 w_vin;
        logic [SEG-1:0]       w_s;
        logic                 w_cout;
        logic                 r_v;
        logic                 r_c;
        logic [(k+1)*SEG-1:0] r_res;

        adder_seg_ripple #(
            .SEG (SEG)
        ) u_seg (
            .i_a    (w_a_rem[SEG-1:0]),
            .i_b    (w_b_rem[SEG-1:0]),
            .i_cin  (w_cin),
            .o_s    (w_s),
            .o_cout (w_cout)
        );

        // Stage valid and segment carry advance with the pipe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_vin;
                r_c <= w_cout;
            end
        end

        if (k == 0) begin : g_head
            assign w_a_rem = a;
            assign w_b_rem = b;
            assign w_cin   = cin;
            assign w_vin   = in_valid;

            // First result segment.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_res <= '0;
                end else if (w_adv) begin
                    r_res <= w_s;
                end
            end
        end else begin : g_body
            assign w_a_rem = g_st[k-1].g_skew.r_ask;
            assign w_b_rem = g_st[k-1].g_skew.r_bsk;
            assign w_cin   = g_st[k-1].r_c;
            assign w_vin   = g_st[k-1].r_v;

            // Append this segment above the deskewed lower segments.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_res <= '0;
                end else if (w_adv) begin
                    r_res <= {w_s, g_st[k-1].r_res};
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [REM-SEG-1:0] r_ask;
            logic [REM-SEG-1:0] r_bsk;

            // Carry the not-yet-added operand segments to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ask <= '0;
                    r_bsk <= '0;
                end else if (w_adv) begin
                    r_ask <= w_a_rem[REM-1:SEG];
                    r_bsk <= w_b_rem[REM-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign sum       = g_st[STAGES-1].r_res;
    assign cout      = g_st[STAGES-1].r_c;

endmodule

// File: doc/adder_pipe_seg.md
Name: adder_pipe_seg

Overview:
- Pipelined wide two-operand adder: a WIDTH-bit add is split into SEG-bit segments, one segment per pipeline stage, with the carry registered between stages.
- Sits directly downstream of the full-adder cell (adder_full). Each segment adder is a ripple chain of adder_full instances.
- Used as the final carry-propagate adder after partial-product reduction in the vedic multiplier, where a single-cycle full-width ripple would not close timing.
- Streams one add per cycle under a valid/ready handshake.

Parameters:
- WIDTH, 64, operand/result width; must be an integer multiple of SEG.
- SEG, 16, bits per pipeline segment (ripple length per stage).
- STAGES, WIDTH/SEG, derived localparam; pipeline depth and latency in cycles.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  a+b+cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. All flops clear on rst_n=0 regardless of clk.
- Reset values: out_valid=0, sum=0, cout=0, all stage valid bits 0, all carry/skew/deskew registers 0. in_ready=1 once reset is released, because the pipe is empty.
- Global advance enable: adv = out_ready | ~out_valid. in_ready = adv, combinational, with no dependence on in_valid.
- Beat transfer: a beat is accepted when in_valid & in_ready. An output beat completes when out_valid & out_ready.
- Stage 0 (on accept, when adv): adds a[SEG-1:0] + b[SEG-1:0] + cin. It registers the SEG-bit result, its carry, and the upper segments of a and b, and sets v[0]=in_valid.
- Stage k, 1..STAGES-1 (when adv): adds segment k of the skewed operands plus the registered carry from stage k-1. It registers the new segment result and forwards the lower result segments through deskew registers. v[k]=v[k-1].
- Output: out_valid = v[STAGES-1]. sum is the concatenation of all deskewed segments. cout is the carry of the last stage.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+STAGES-1. Equivalently, it is valid during the STAGES-th cycle after acceptance; that is cycle 4 for WIDTH=64, SEG=16.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: when adv=0, every pipeline register (data, carry, valid) holds. No beat is dropped or duplicated, order is preserved, and sum/cout stay stable while out_valid=1 and out_ready=0.
- Bubbles: stages with v=0 still clock data when adv=1, but their contents are don't-care and must never reach out_valid=1.
- Simultaneous accept and output: legal in the same cycle; the pipe shifts by one.
- Arithmetic: the carry chain is unsigned and wraps modulo 2^WIDTH. There is no overflow flag beyond cout.
- Reset mid-operation: all in-flight beats are discarded immediately. out_valid drops to 0 asynchronously, and no stale result appears after release.
- Parameter check: elaboration fails (generate-time error) if WIDTH % SEG != 0 or SEG < 1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, sum=0, cout=0, in_ready=1.
- Full carry propagation: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1, out_ready=1 -> out_valid on cycle 4 after accept with sum=0, cout=1. Also a=64'h0000_0000_FFFF_FFFF, b=1, cin=0 -> sum=64'h0000_0001_0000_0000, cout=0.
- Streaming: accept (1,2,0), (10,20,1), (2^63,2^63,0) on consecutive cycles -> results 3, 31, then sum=0/cout=1, on consecutive cycles starting at cycle 4.
- Backpressure: with 3 beats in flight, hold out_ready=0 for 5 cycles -> in_ready=0, sum/cout held constant, no new beats accepted. After out_ready=1, the remaining results emerge in order with none lost.
- Reset mid-flight: assert rst_n=0 with 2 beats in flight -> out_valid=0 in the same cycle. After release, no output appears until a new beat is accepted.
- Random regression: 2000 random (a,b,cin) with random in_valid/out_ready toggling, checked against a+b+cin on a 65-bit scoreboard -> zero mismatches, zero drops, in-order delivery.
